// File: rtl/vga_fb_pkg.sv
// Shared constants, the host write record and the RGB332 colour expansion
// used by the VGA framebuffer scheduler.
package vga_fb_pkg;
    localparam int FB_W       = 160;
    localparam int FB_H       = 120;
    localparam int X_START    = 140;
    localparam int Y_START    = 34;
    localparam int ACT_W      = 640;
    localparam int ACT_H      = 480;
    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 15;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } fb_wr_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Bit replication maps full-scale 3/2-bit fields onto full-scale 8-bit ones.
    function automatic rgb888_t expand_rgb332(input logic [7:0] p);
        rgb888_t c;
        c.r = {p[7:5], p[7:5], p[7:6]};
        c.g = {p[4:2], p[4:2], p[4:3]};
        c.b = {4{p[1:0]}};
        return c;
    endfunction
endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO holding host pixel writes until the RAM port is free.
module fb_wr_fifo
    import vga_fb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push_i,
    input  fb_wr_t data_i,
    input  logic   pop_i,
    output fb_wr_t data_o,
    output logic   full_o,
    output logic   empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    fb_wr_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // NOTE: every output of this block is defaulted first, so no path leaves a latch behind.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_ok && !pop_ok)      cnt_d = cnt_q + (PTR_W+1)'(1);
        else if (pop_ok && !push_ok) cnt_d = cnt_q - (PTR_W+1)'(1);
    end

    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: storage is not reset; the count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/vga_fb_scheduler.sv
// Shares one framebuffer RAM port between 4x-scaled display fetch and
// buffered host writes; display slots always win, writes are only delayed.
module vga_fb_scheduler #(
    parameter int FB_W       = vga_fb_pkg::FB_W,
    parameter int FB_H       = vga_fb_pkg::FB_H,
    parameter int X_START    = vga_fb_pkg::X_START,
    parameter int Y_START    = vga_fb_pkg::Y_START,
    parameter int FIFO_DEPTH = vga_fb_pkg::FIFO_DEPTH,
    parameter int ADDR_W     = vga_fb_pkg::ADDR_W
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic [9:0]        H_Cont,
    input  logic [9:0]        V_Cont,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [7:0]        oRed,
    output logic [7:0]        oGreen,
    output logic [7:0]        oBlue,
    output logic              o_vblank
);
    import vga_fb_pkg::*;

    localparam logic [10:0]       H_ACT_LO = 11'(X_START);
    localparam logic [10:0]       H_ACT_HI = 11'(X_START + ACT_W);
    localparam logic [10:0]       V_ACT_LO = 11'(Y_START);
    localparam logic [10:0]       V_ACT_HI = 11'(Y_START + ACT_H);
    localparam logic [10:0]       SLOT_LO  = 11'(X_START - 2);
    localparam logic [10:0]       SLOT_HI  = 11'(X_START + ACT_W - 6);
    localparam logic [ADDR_W-1:0] FB_PIX   = ADDR_W'(FB_W * FB_H);
    localparam logic [ADDR_W-1:0] ROW_INC  = ADDR_W'(FB_W);

    logic [10:0]       h_ext, v_ext, h_off;
    logic [1:0]        y_phase;
    logic              h_act, v_act, slot, line_end, pop, head_ok;
    logic              run_q, slot_q;
    logic [7:0]        pix_q, pix_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d, slot_addr;
    logic              fifo_full, fifo_empty;
    fb_wr_t            wr_in, head;
    rgb888_t           rgb;

    assign h_ext   = {1'b0, H_Cont};
    assign v_ext   = {1'b0, V_Cont};
    assign h_act   = (h_ext >= H_ACT_LO) && (h_ext < H_ACT_HI);
    assign v_act   = (v_ext >= V_ACT_LO) && (v_ext < V_ACT_HI);
    assign h_off   = h_ext - SLOT_LO;
    assign y_phase = V_Cont[1:0] - 2'(Y_START);

    // run_q keeps the RAM port parked at address 0 while reset is held.
    assign slot      = run_q && v_act && (h_ext >= SLOT_LO) && (h_ext <= SLOT_HI)
                       && (h_off[1:0] == 2'b00);
    assign slot_addr = row_base_q + ADDR_W'(h_off[10:2]);
    assign line_end  = v_act && (h_ext == H_ACT_HI) && (y_phase == 2'b11);

    always_comb begin
        row_base_d = row_base_q;
        if (V_Cont == '0)  row_base_d = '0;
        else if (line_end) row_base_d = row_base_q + ROW_INC;
    end

    assign wr_in = '{addr: wr_addr, data: wr_data};
    assign pop   = !slot && !fifo_empty;

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk     (iCLK),
        .rst_n   (iRST_N),
        .push_i  (wr_valid),
        .data_i  (wr_in),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign wr_ready = !fifo_full;
    assign head_ok  = (head.addr < FB_PIX);

    // Out-of-range writes still pop, but never reach the RAM.
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (slot) begin
            ram_addr = slot_addr;
        end else if (!fifo_empty && head_ok) begin
            ram_addr  = head.addr;
            ram_we    = 1'b1;
            ram_wdata = head.data;
        end
    end

    assign pix_d = slot_q ? ram_rdata : pix_q;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            run_q      <= 1'b0;
            slot_q     <= 1'b0;
            pix_q      <= '0;
            row_base_q <= '0;
        end else begin
            run_q      <= 1'b1;
            slot_q     <= slot;
            pix_q      <= pix_d;
            row_base_q <= row_base_d;
        end
    end

    assign rgb      = expand_rgb332(pix_q);
    assign oRed     = (h_act && v_act) ? rgb.r : '0;
    assign oGreen   = (h_act && v_act) ? rgb.g : '0;
    assign oBlue    = (h_act && v_act) ? rgb.b : '0;
    assign o_vblank = !v_act;
endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Scoreboard bench: expected RAM writes are queued at acceptance and a
// monitor compares them when the DUT drives ram_we; display is checked directly.
module tb_vga_fb_scheduler;
    import vga_fb_pkg::*;

    logic        iCLK = 1'b0;
    logic        iRST_N;
    logic [9:0]  H_Cont, V_Cont;
    logic        wr_valid;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata, ram_rdata;
    logic [7:0]  oRed, oGreen, oBlue;
    logic        o_vblank;

    int     n_checks = 0;
    int     n_fail   = 0;
    fb_wr_t sb_q[$];
    bit     chk_occ  = 1'b0;
    bit     saw_full = 1'b0;
    logic [7:0] mem [0:32767];

    always #5 iCLK = ~iCLK;

    vga_fb_scheduler dut (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .H_Cont    (H_Cont),
        .V_Cont    (V_Cont),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .oRed      (oRed),
        .oGreen    (oGreen),
        .oBlue     (oBlue),
        .o_vblank  (o_vblank)
    );

    always @(posedge iCLK) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit is_slot(input int h, input int v);
        return (v >= 34) && (v < 514) && (h >= 138) && (h <= 774) && ((h % 4) == 2);
    endfunction

    // One pixel clock: inputs change just after the edge, outputs are read at the falling edge.
    task automatic clk_cycle(input int h, input int v, input bit vld, input int addr,
                             input int data, output bit acc);
        @(posedge iCLK);
        #1;
        H_Cont   = 10'(h);
        V_Cont   = 10'(v);
        wr_valid = vld;
        wr_addr  = 15'(addr);
        wr_data  = 8'(data);
        if (chk_occ) begin
            check("wr_ready_vs_occupancy", 32'(wr_ready), 32'(sb_q.size() < 4));
            if (!wr_ready) saw_full = 1'b1;
        end
        @(negedge iCLK);
        acc = wr_valid && wr_ready && iRST_N;
        if (acc && (addr < 19200)) sb_q.push_back('{addr: wr_addr, data: wr_data});
    endtask

    always @(negedge iCLK) begin
        if (iRST_N && ram_we) begin
            check("we_in_slot", 32'(is_slot(int'(H_Cont), int'(V_Cont))), 32'd0);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                         ram_addr, ram_wdata);
            end else begin
                fb_wr_t e;
                e = sb_q.pop_front();
                check("write_addr", 32'(ram_addr), 32'(e.addr));
                check("write_data", 32'(ram_wdata), 32'(e.data));
            end
        end
    end

    initial begin
        bit acc;
        int h;
        int idx;
        bit hit;

        for (int a = 0; a < 32768; a++) mem[a] = 8'(a);
        iRST_N = 1'b0; H_Cont = '0; V_Cont = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        #1;
        check("reset_wr_ready", 32'(wr_ready), 32'd1);
        check("reset_ram_we",   32'(ram_we),   32'd0);
        check("reset_ram_addr", 32'(ram_addr), 32'd0);
        check("reset_rgb",      {8'h0, oRed, oGreen, oBlue}, 32'h0);
        check("reset_vblank",   32'(o_vblank), 32'd1);
        repeat (3) @(posedge iCLK);
        #1 iRST_N = 1'b1;

        // Display sweep of the first active line, RAM holds addr==data.
        for (int hh = 0; hh <= 800; hh++) begin
            clk_cycle(hh, 34, 1'b0, 0, 0, acc);
            if (is_slot(hh, 34)) begin
                check("slot_addr", 32'(ram_addr), 32'((hh - 138) / 4));
                check("slot_we",   32'(ram_we),   32'd0);
            end else begin
                check("idle_addr", 32'(ram_addr), 32'd0);
                check("idle_we",   32'(ram_we),   32'd0);
            end
            case (hh)
                139, 140, 143, 780: check($sformatf("rgb_h%0d", hh), {8'h0, oRed, oGreen, oBlue}, 32'h000000);
                144: check("rgb_h144", {8'h0, oRed, oGreen, oBlue}, 32'h000055);
                148: check("rgb_h148", {8'h0, oRed, oGreen, oBlue}, 32'h0000AA);
                285: check("rgb_h285", {8'h0, oRed, oGreen, oBlue}, 32'h242400);
                577: check("rgb_h577", {8'h0, oRed, oGreen, oBlue}, 32'h6D6D55);
                779: check("rgb_h779", {8'h0, oRed, oGreen, oBlue}, 32'h92FFFF);
                400: check("vblank_active", 32'(o_vblank), 32'd0);
                default: ;
            endcase
        end

        // Row base walk: only the end-of-line cycle of each line is driven.
        clk_cycle(0, 0, 1'b0, 0, 0, acc);
        for (int v = 34; v < 38; v++) clk_cycle(780, v, 1'b0, 0, 0, acc);
        clk_cycle(138, 38, 1'b0, 0, 0, acc);
        check("row1_first_slot", 32'(ram_addr), 32'd160);
        for (int v = 38; v < 513; v++) clk_cycle(780, v, 1'b0, 0, 0, acc);
        clk_cycle(138, 513, 1'b0, 0, 0, acc);
        check("row119_first_slot", 32'(ram_addr), 32'd19040);
        clk_cycle(774, 513, 1'b0, 0, 0, acc);
        check("row119_last_slot", 32'(ram_addr), 32'd19199);
        clk_cycle(800, 528, 1'b0, 0, 0, acc);
        check("inactive_addr",   32'(ram_addr), 32'd0);
        check("inactive_rgb",    {8'h0, oRed, oGreen, oBlue}, 32'h0);
        check("inactive_vblank", 32'(o_vblank), 32'd1);
        clk_cycle(138, 33, 1'b0, 0, 0, acc);
        check("pre_active_addr",   32'(ram_addr), 32'd0);
        check("pre_active_vblank", 32'(o_vblank), 32'd1);
        clk_cycle(0, 0, 1'b0, 0, 0, acc);

        // Sustained host burst during an active line fills the FIFO.
        chk_occ = 1'b1; saw_full = 1'b0; idx = 0; h = 140;
        while (idx < 20 && h < 740) begin
            clk_cycle(h, 34, 1'b1, 5000 + idx, 8'h30 + idx, acc);
            if (acc) idx++;
            h++;
        end
        while (h < 780) begin
            clk_cycle(h, 34, 1'b0, 0, 0, acc);
            h++;
        end
        chk_occ = 1'b0;
        check("burst_all_accepted", 32'(idx), 32'd20);
        check("burst_saw_full",     32'(saw_full), 32'd1);
        check("burst_drained",      32'(sb_q.size()), 32'd0);

        // Reset mid-line with writes still queued.
        clk_cycle(0, 0, 1'b0, 0, 0, acc);
        idx = 0; h = 140;
        while (h < 700) begin
            clk_cycle(h, 34, 1'b1, 6000 + idx, 8'hC0 + idx, acc);
            if (acc) idx++;
            if (sb_q.size() >= 3) break;
            h++;
        end
        hit = (sb_q.size() >= 3);
        check("reset_precondition_queued", 32'(hit), 32'd1);
        iRST_N = 1'b0;
        #1;
        sb_q.delete();
        check("midreset_rgb",      {8'h0, oRed, oGreen, oBlue}, 32'h0);
        check("midreset_ram_we",   32'(ram_we),   32'd0);
        check("midreset_wr_ready", 32'(wr_ready), 32'd1);
        check("midreset_ram_addr", 32'(ram_addr), 32'd0);
        for (int i = 0; i < 2; i++) begin
            h++;
            clk_cycle(h, 34, 1'b0, 0, 0, acc);
            check("held_reset_ram_we", 32'(ram_we), 32'd0);
        end
        iRST_N = 1'b1;
        #1;
        check("release_rgb", {8'h0, oRed, oGreen, oBlue}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            h++;
            clk_cycle(h, 34, 1'b0, 0, 0, acc);
            if (is_slot(h, 34)) begin
                check("resume_slot_addr", 32'(ram_addr), 32'((h - 138) / 4));
                break;
            end
        end

        // Blanking writes: out-of-range discard, then 1-cycle latency and full rate.
        clk_cycle(0, 520, 1'b1, 19200, 8'hAB, acc);
        check("oob_accepted", 32'(acc), 32'd1);
        clk_cycle(1, 520, 1'b0, 0, 0, acc);
        check("oob_no_we",   32'(ram_we),   32'd0);
        check("oob_no_addr", 32'(ram_addr), 32'd0);
        clk_cycle(2, 520, 1'b1, 0, 8'h5A, acc);
        check("blank_wr_accepted", 32'(acc), 32'd1);
        clk_cycle(3, 520, 1'b0, 0, 0, acc);
        check("blank_wr_we",    32'(ram_we),    32'd1);
        check("blank_wr_addr",  32'(ram_addr),  32'd0);
        check("blank_wr_wdata", 32'(ram_wdata), 32'h5A);
        for (int i = 0; i < 4; i++) begin
            clk_cycle(4 + i, 520, 1'b1, 100 + i, 8'h10 + i, acc);
            check("blank_rate_accepted", 32'(acc), 32'd1);
        end
        repeat (4) clk_cycle(20, 520, 1'b0, 0, 0, acc);
        check("final_sb_empty", 32'(sb_q.size()), 32'd0);
        check("final_mem_100",  32'(mem[100]), 32'h10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_fb_scheduler.md
# vga_fb_scheduler

Schedules a single-port on-chip framebuffer between pixel fetch for `VGA_Controller` and a host write port. Each cycle it decides whether the RAM serves a display read or a buffered host write. It stores a 160x120 RGB332 image and scales it 4x to fill the 640x480 active window. It sits between the host/CPU write path and the controller's `iRed/iGreen/iBlue` inputs, and is driven by the controller's `H_Cont/V_Cont`.

## Interface
- `FB_W`, 160: framebuffer width in pixels.
- `FB_H`, 120: framebuffer height in pixels.
- `X_START`, 140: first active `H_Cont` value (sync + back porch).
- `Y_START`, 34: first active `V_Cont` value.
- `FIFO_DEPTH`, 4: host write FIFO entries (power of 2).
- `ADDR_W`, 15: RAM address width.
- `iCLK` in 1: pixel clock, the same clock as `VGA_Controller`.
- `iRST_N` in 1: asynchronous, active-low reset.
- `H_Cont` in 10: horizontal counter from the controller.
- `V_Cont` in 10: vertical counter from the controller.
- `wr_valid` in 1: host write request.
- `wr_addr` in ADDR_W: host pixel address (y*160+x).
- `wr_data` in 8: host pixel, RGB332.
- `wr_ready` out 1: FIFO can accept a write.
- `ram_addr` out ADDR_W: RAM address.
- `ram_we` out 1: RAM write enable.
- `ram_wdata` out 8: RAM write data.
- `ram_rdata` in 8: RAM read data, valid 1 cycle after the address.
- `oRed`, `oGreen`, `oBlue` out 8 each: colour to the controller's `iRed/iGreen/iBlue`.
- `o_vblank` out 1: V_Cont is outside the active lines.

## Operation
- Active region:
  - H_act = X_START ≤ H_Cont < X_START+640.
  - V_act = Y_START ≤ V_Cont < Y_START+480.
  - x = H_Cont−X_START, y = V_Cont−Y_START.
- Display slot: asserted when V_act, X_START−2 ≤ H_Cont ≤ X_START+634, and (H_Cont−(X_START−2))%4==0. With default parameters this is H_Cont[1:0]==2'b10, giving 160 slots per active line.
- In a slot cycle: `ram_addr` = (y>>2)*FB_W + k, where k is the slot index 0..159; `ram_we`=0.
  - Row base is kept in a register, advanced by FB_W every 4th active line and cleared when V_Cont=0. There is no multiplier.
- Slot+1 cycle: `ram_rdata` is loaded into the pixel register `pix`.
- Non-slot cycle with a non-empty FIFO: pop the head; `ram_addr`=head addr, `ram_we`=1, `ram_wdata`=head data.
- Otherwise: `ram_we`=0 and `ram_addr`=0.
- The display always has priority. Host writes are never dropped, only delayed.
- FIFO behaviour:
  - `wr_ready` = !full.
  - A push occurs on `wr_valid && wr_ready`.
  - Push and pop in the same cycle are both honoured and the count is unchanged.
  - There is no write-through from input to RAM in the push cycle.
- Colour output (combinational from `pix`, H_act and V_act):
  - R = {p[7:5],p[7:5],p[7:6]}
  - G = {p[4:2],p[4:2],p[4:3]}
  - B = {p[1:0]×4}
  - All three outputs are 0 when !(H_act && V_act).
- `o_vblank` = !V_act.
- Host writes with addr ≥ FB_W*FB_H are accepted and discarded at pop (`ram_we` stays 0).

## Timing
- Display latency: slot at H_Cont=h; `pix` is valid for H_Cont = h+2 .. h+5. This covers exactly the 4 scaled pixels x=4k..4k+3.
- Host write latency: minimum 1 cycle from acceptance to `ram_we`. During active lines the worst case is one slot (1 cycle) of extra stall.
- Worst-case host bandwidth during an active line is 3 writes per 4 cycles. During blanking it is 1 write per cycle.
- Reset values, asserted asynchronously:
  - FIFO empty, `wr_ready`=1.
  - `pix`=0, RGB=0, `ram_we`=0, `ram_addr`=0, row base=0.
  - `o_vblank` follows V_Cont combinationally.
- Reset mid-write flushes the FIFO, and queued writes are lost. Reset mid-line blanks output until the next slot.
- H_Cont=800 and V_Cont=528 are legal inactive values. They produce no slot and no address wrap hazard.

## Structure
- Package `vga_fb_pkg`: timing constants (X_START, Y_START, active sizes, FB_W/FB_H), the RGB332 expand function, and the `fb_wr_t` struct {addr, data}.
- Sub-module `fb_wr_fifo`: synchronous FIFO of `fb_wr_t`, DEPTH parameter, full/empty, async active-low reset.
- Top level: slot decode, row-base/column counters, RAM mux, `pix` register, colour expansion.

## Test plan
- Idle RAM preloaded with addr==data[7:0], V_Cont=Y_START, H_Cont sweeping 0..800: `ram_addr` 0..159 at H_Cont=138,142,…,774. RGB for H_Cont=140..143 is expand(0x00); for H_Cont=144 it is expand(0x01). RGB is 0 at H_Cont=139 and H_Cont=780.
- Row base: V_Cont=Y_START+4 → first slot addr=160. V_Cont=Y_START+479 → first slot addr=119*160=19040.
- Host burst of 6 writes during an active line with FIFO_DEPTH=4: `wr_ready` drops after 4 pending entries. No `ram_we` occurs in any slot cycle. All 6 writes land, in order, on the correct addresses.
- Push and pop in the same cycle with the FIFO at 3 entries: count stays 3 and data order is preserved.
- Write to addr 19200 → accepted, no `ram_we`. Write to 0 in blanking → `ram_we` 1 cycle after acceptance.
- Assert `iRST_N` low with 3 queued writes, mid-line: RGB=0, `ram_we`=0, `wr_ready`=1 immediately. After release, the next slot resumes the correct address.
